// File: rtl/ir_pkg.sv
// Shared constants and types for the MIPS instruction register queue.
// Imported by the interface, storage array and queue control.
package ir_pkg;

    localparam int IR_WIDTH_DEFAULT = 32;
    localparam logic [31:0] IR_NOP = 32'h0000_0000;

    typedef struct packed {
        logic push;
        logic pop;
    } ir_op_t;

endpackage

// File: rtl/ir_queue_if.sv
// Fetch/control-side bundle of the instruction register queue.
// The master drives push/pop/flush/enable; the slave returns data and status.
interface ir_queue_if
    import ir_pkg::*;
#(
    parameter int WIDTH = IR_WIDTH_DEFAULT,
    parameter int DEPTH = 4
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             ir_in;
    logic [WIDTH-1:0] ir_wdata;
    logic             ir_next;
    logic             flush;
    logic             ir_out;
    logic [WIDTH-1:0] ir_rdata;
    logic             ir_valid;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             overflow;

    modport master (
        output ir_in, ir_wdata, ir_next, flush, ir_out,
        input  ir_rdata, ir_valid, full, count, overflow
    );

    modport slave (
        input  ir_in, ir_wdata, ir_next, flush, ir_out,
        output ir_rdata, ir_valid, full, count, overflow
    );

endinterface

// File: rtl/ir_queue_mem.sv
// DEPTH x WIDTH register array, one write port and one asynchronous
// read port, written on the falling (datapath capture) edge.
module ir_queue_mem
    import ir_pkg::*;
#(
    parameter int WIDTH = IR_WIDTH_DEFAULT,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    if (DEPTH > 1) begin : g_array
        always_ff @(negedge clk) begin
            if (i_we) begin
                r_mem[i_waddr] <= i_wdata;
            end
        end
        assign o_rdata = r_mem[i_raddr];
    end else begin : g_single
        always_ff @(negedge clk) begin
            if (i_we) begin
                r_mem[0] <= i_wdata;
            end
        end
        assign o_rdata = r_mem[0];
    end

endmodule

// File: rtl/ir_queue.sv
// Instruction register queue: circular buffer control, occupancy count,
// sticky overflow flag and ir_out gating of the head word.
module ir_queue
    import ir_pkg::*;
#(
    parameter int WIDTH = IR_WIDTH_DEFAULT,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic       clk,
    input  logic       rst,
    ir_queue_if.slave  bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             w_empty;
    logic             w_full;
    logic             w_drop;
    logic             w_we;
    ir_op_t           w_op;
    logic [AW-1:0]    w_rd_ptr;
    logic [AW-1:0]    w_wr_ptr;
    logic [WIDTH-1:0] w_head;

    // A pop on a full queue frees the slot the same-cycle push lands in.
    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == CNT_W'(DEPTH));
        w_op    = '0;
        w_op.pop  = bus.ir_next && !w_empty;
        w_op.push = bus.ir_in && (!w_full || w_op.pop);
        w_drop  = bus.ir_in && w_full && !bus.ir_next;
        w_we    = w_op.push && !bus.flush && !rst;
    end

    if (DEPTH > 1) begin : g_ptr
        logic [AW-1:0] r_rd_ptr;
        logic [AW-1:0] r_wr_ptr;

        always_ff @(negedge clk) begin
            if (rst || bus.flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_op.push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_op.pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end
        end

        assign w_rd_ptr = r_rd_ptr;
        assign w_wr_ptr = r_wr_ptr;
    end else begin : g_no_ptr
        assign w_rd_ptr = '0;
        assign w_wr_ptr = '0;
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.flush) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            case ({w_op.push, w_op.pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    ir_queue_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_wr_ptr),
        .i_wdata (bus.ir_wdata),
        .i_raddr (w_rd_ptr),
        .o_rdata (w_head)
    );

    assign bus.ir_valid = !w_empty;
    assign bus.full     = w_full;
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;
    assign bus.ir_rdata = (bus.ir_out && !w_empty) ? w_head : WIDTH'(IR_NOP);

endmodule
